mem_arbiter: RTL and testbench

Two-requester arbiter for the core's single-port RAM. It shares one memory port between the instruction-fetch path and the load/store data path. It issues one access at a time, tracks the fixed read latency of the memory, and returns read data to the requester that owns the access. It sits between the core pipeline and the `ram` instance, replacing the direct stage-driven memory hookup.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port RAM between instruction fetch
// and load/store. One access in flight at a time; fixed read latency MEM_LAT.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [2:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [2:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_d;   // 1: data path owned the most recent grant
  logic             owner_d;  // 1: outstanding read belongs to the data path
  logic             grant_any;
  logic             pick_d;
  logic             d_legal_wr;

  // Arbitration and memory port drive; only IDLE may grant, nothing during reset.
  always_comb begin
    grant_any  = 1'b0;
    pick_d     = 1'b0;
    d_legal_wr = (d_we == 3'b100) || (d_we == 3'b010) || (d_we == 3'b001);
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (rst_n && (state == IDLE)) begin
      grant_any = if_req || d_req;
      pick_d    = (if_req && d_req) ? !last_d : d_req;
    end
    if (grant_any) begin
      mem_en = 1'b1;
      if (pick_d) begin
        d_gnt     = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_we    = d_legal_wr ? d_we : 3'b000;
      end else begin
        if_gnt   = 1'b1;
        mem_addr = if_addr;
      end
    end
  end

  // Access tracking, read-latency countdown and registered read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b1;
      owner_d   <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_d <= pick_d;
            // Legal writes finish in the grant cycle; everything else is a read.
            if (!(pick_d && d_legal_wr)) begin
              state   <= WAIT;
              owner_d <= pick_d;
              cnt     <= CNT_W'(MEM_LAT);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
            if (owner_d) begin
              d_rdata  <= mem_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: constant vector table, directed corner sequences and
// a randomized run checked against a cycle-count based reference model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, d_req;
  logic [ADDR_W-1:0] if_addr, d_addr, mem_addr;
  logic [2:0]        d_we, mem_we;
  logic [DATA_W-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic              if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: the port is free again at free_cyc; one pending return.
  int          free_cyc;
  bit          last_d;
  bit          pend, pend_d;
  int          rv_cyc;
  logic [31:0] m_if_rdata, m_d_rdata;
  bit          m_if_gnt, m_d_gnt;

  typedef struct {
    bit          if_req, d_req;
    logic [2:0]  we;
    logic [31:0] if_addr, d_addr, d_wdata;
    bit          e_ifg, e_dg;
    logic [2:0]  e_we;
    logic [31:0] e_addr, e_wd;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    free_cyc   = 0;
    last_d     = 1'b1;
    pend       = 1'b0;
    pend_d     = 1'b0;
    rv_cyc     = 0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
  endtask

  // Sample at the falling edge, compare every output with the model, then step the model.
  task automatic sample();
    bit          e_en, e_ifg, e_dg, e_ifrv, e_drv, win_d, wr;
    logic [2:0]  e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    e_en = 0; e_ifg = 0; e_dg = 0; e_ifrv = 0; e_drv = 0; win_d = 0; wr = 0;
    e_we = '0; e_addr = '0; e_wd = '0;
    if (!rst_n) begin
      model_reset();
    end else begin
      e_ifrv = pend && (rv_cyc == cyc) && !pend_d;
      e_drv  = pend && (rv_cyc == cyc) && pend_d;
      if ((cyc >= free_cyc) && (if_req || d_req)) begin
        win_d = (if_req && d_req) ? !last_d : d_req;
        e_en  = 1;
        if (win_d) begin
          e_dg   = 1;
          e_addr = d_addr;
          e_wd   = d_wdata;
          wr     = ($countones(d_we) == 1);
          e_we   = wr ? d_we : 3'b000;
        end else begin
          e_ifg  = 1;
          e_addr = if_addr;
        end
      end
    end
    chk("if_gnt", if_gnt, e_ifg);
    chk("d_gnt", d_gnt, e_dg);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("if_rvalid", if_rvalid, e_ifrv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    m_if_gnt = e_ifg;
    m_d_gnt  = e_dg;
    if (rst_n) begin
      if (pend && (cyc == rv_cyc - 1)) begin
        if (pend_d) m_d_rdata = mem_rdata;
        else        m_if_rdata = mem_rdata;
      end
      if (pend && (cyc == rv_cyc)) pend = 0;
      if (e_en) begin
        last_d = win_d;
        if (win_d && wr) free_cyc = cyc + 1;
        else begin
          free_cyc = cyc + int'(LAT) + 1;
          rv_cyc   = cyc + int'(LAT) + 1;
          pend     = 1;
          pend_d   = win_d;
        end
      end
    end
  endtask

  // Move to just after the next rising edge; granted requesters drop req.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (m_if_gnt) if_req = 1'b0;
    if (m_d_gnt)  d_req  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((if_req || d_req || (cyc < free_cyc)) && (n < 30)) begin
      sample();
      advance();
      n++;
    end
    chk("drain_bound", 32'(n < 30), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample();
    advance();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 0, 3'b000, 32'h10, 32'h0,  32'h0,    1, 0, 3'b000, 32'h10, 32'h0};
    tbl[1]  = '{0, 1, 3'b000, 32'h0,  32'h20, 32'h11,   0, 1, 3'b000, 32'h20, 32'h11};
    tbl[2]  = '{0, 1, 3'b100, 32'h0,  32'h4,  32'hAB,   0, 1, 3'b100, 32'h4,  32'hAB};
    tbl[3]  = '{1, 1, 3'b000, 32'h30, 32'h40, 32'h0,    1, 0, 3'b000, 32'h30, 32'h0};
    tbl[4]  = '{1, 1, 3'b010, 32'h60, 32'h50, 32'h1234, 1, 0, 3'b000, 32'h60, 32'h0};
    tbl[5]  = '{0, 1, 3'b011, 32'h0,  32'h70, 32'h55,   0, 1, 3'b000, 32'h70, 32'h55};
    tbl[6]  = '{0, 1, 3'b001, 32'h0,  32'h80, 32'hCAFE, 0, 1, 3'b001, 32'h80, 32'hCAFE};
    tbl[7]  = '{1, 0, 3'b000, 32'h90, 32'h0,  32'h0,    1, 0, 3'b000, 32'h90, 32'h0};
    tbl[8]  = '{1, 1, 3'b000, 32'hB0, 32'hA0, 32'h0,    0, 1, 3'b000, 32'hA0, 32'h0};
    tbl[9]  = '{1, 1, 3'b100, 32'hD0, 32'hC0, 32'hFF,   0, 1, 3'b100, 32'hC0, 32'hFF};
    tbl[10] = '{0, 0, 3'b000, 32'h0,  32'h0,  32'h0,    0, 0, 3'b000, 32'h0,  32'h0};

    model_reset();
    rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h1; d_addr = 32'h2;
    d_we = 3'b000; d_wdata = 32'h3; mem_rdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset held with both requesters active, then release with nothing requesting.
    sample();
    chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    advance();
    rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0;
    sample();
    chk("rel_idle", {29'd0, if_gnt, d_gnt, mem_en}, 32'd0);
    advance();

    // Single fetch: data returns LAT cycles after issue, rvalid one later.
    if_req = 1'b1; if_addr = 32'h10;
    sample();
    chk("fetch_addr", mem_addr, 32'h10);
    chk("fetch_gnt", if_gnt, 1'b1);
    advance();
    for (int k = 1; k <= int'(LAT); k++) begin
      mem_rdata = (k == int'(LAT)) ? 32'hDEADBEEF : 32'h0;
      sample();
      chk("fetch_wait_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
      advance();
    end
    mem_rdata = 32'h0;
    sample();
    chk("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
    chk("fetch_d_rvalid", d_rvalid, 1'b0);
    advance();
    drain();

    // Continuous tie from reset: fetch, data, fetch, each LAT+1 apart.
    do_reset();
    for (int k = 0; k <= 2 * (int'(LAT) + 1); k++) begin
      if_req = 1'b1; d_req = 1'b1; if_addr = 32'h100; d_addr = 32'h200;
      d_we = 3'b000; d_wdata = 32'h0; mem_rdata = 32'(k) + 32'h500;
      sample();
      if (k == 0) chk("tie_first_if", if_gnt, 1'b1);
      if (k == int'(LAT) + 1) begin
        chk("tie_second_d", d_gnt, 1'b1);
        chk("tie_if_rvalid", if_rvalid, 1'b1);
      end
      if (k == 2 * (int'(LAT) + 1)) begin
        chk("tie_third_if", if_gnt, 1'b1);
        chk("tie_d_rvalid", d_rvalid, 1'b1);
      end
      advance();
    end
    if_req = 1'b0; d_req = 1'b0;
    drain();

    // Byte store completes in one cycle; fetch granted right behind it.
    d_req = 1'b1; d_we = 3'b100; d_addr = 32'h4; d_wdata = 32'hAB;
    sample();
    chk("st_we", mem_we, 3'b100);
    chk("st_wdata", mem_wdata, 32'hAB);
    advance();
    if_req = 1'b1; if_addr = 32'h44;
    sample();
    chk("st_then_fetch", if_gnt, 1'b1);
    advance();
    drain();

    // Reset during an outstanding data read abandons it.
    d_req = 1'b1; d_we = 3'b000; d_addr = 32'h88; mem_rdata = 32'h77;
    sample();
    chk("rr_gnt", d_gnt, 1'b1);
    advance();
    sample();
    advance();
    rst_n = 1'b0;
    sample();
    advance();
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h99;
    sample();
    chk("rr_regrant", if_gnt, 1'b1);
    advance();
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      sample();
      chk("rr_no_d_rvalid", d_rvalid, 1'b0);
      advance();
    end
    drain();

    // Illegal write enable is a read; wdata still forwarded.
    d_req = 1'b1; d_we = 3'b011; d_wdata = 32'h55; d_addr = 32'h70; mem_rdata = 32'h0;
    sample();
    chk("ill_we", mem_we, 3'b000);
    chk("ill_wdata", mem_wdata, 32'h55);
    advance();
    for (int k = 1; k <= int'(LAT); k++) begin
      mem_rdata = (k == int'(LAT)) ? 32'h12345678 : 32'h0;
      sample();
      advance();
    end
    sample();
    chk("ill_rvalid", d_rvalid, 1'b1);
    chk("ill_rdata", d_rdata, 32'h12345678);
    advance();
    drain();

    // Vector table from a fresh reset so the tie history is known.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if_req = tbl[i].if_req; d_req = tbl[i].d_req; d_we = tbl[i].we;
      if_addr = tbl[i].if_addr; d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
      sample();
      chk($sformatf("vec%0d_if_gnt", i), if_gnt, tbl[i].e_ifg);
      chk($sformatf("vec%0d_d_gnt", i), d_gnt, tbl[i].e_dg);
      chk($sformatf("vec%0d_en", i), mem_en, tbl[i].e_ifg | tbl[i].e_dg);
      chk($sformatf("vec%0d_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].e_wd);
      advance();
      drain();
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (!if_req && ($urandom_range(0, 2) == 0)) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!d_req && ($urandom_range(0, 2) == 0)) begin
        int unsigned r;
        r = $urandom_range(0, 7);
        d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
        case (r)
          3: d_we = 3'b100;
          4: d_we = 3'b010;
          5: d_we = 3'b001;
          6: d_we = 3'b011;
          7: d_we = 3'($urandom_range(0, 7));
          default: d_we = 3'b000;
        endcase
      end
      mem_rdata = $urandom;
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      sample();
      advance();
    end
    rst_n = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
